shift_add_mul_ctrl: RTL and testbench
=====================================

// Module: shift_add_mul_ctrl
// PURPOSE
//  Sequencer that drives the 4-bit shift/add ALU to compute an unsigned 4x4 -> 8-bit product.
//  Issues one ALU operation per cycle (ADD or ROR) over a shift-add loop.
//  Consumes ALU result/carry combinationally in the same cycle.
//  Sits between a valid/ready operand source and a valid/ready product sink; ALU is external.
// PARAMETERS
//  DATA_W    4  operand width; must equal ALU width (only 4 supported)
//  SKIP_ADD  1  1: skip ADD cycle when current multiplier bit is 0; 0: always ADD (B=0)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  operands valid
//  in_ready   out  1  controller can accept operands (high only in IDLE)
//  in_a       in   4  multiplicand
//  in_b       in   4  multiplier
//  out_valid  out  1  product valid
//  out_ready  in   1  sink accepts product
//  product    out  8  in_a*in_b, unsigned
//  alu_s      out  4  ALU opcode S[3:0]
//  alu_cin    out  1  ALU carry-in
//  alu_a      out  4  ALU operand A
//  alu_b      out  4  ALU operand B
//  alu_result in   4  ALU result (combinational from alu_* outputs)
//  alu_cout   in   1  ALU carry/rotate-out
// BEHAVIOUR
//  - Regs: ACC[3:0], MPL[3:0], MCD[3:0], C (1b), CNT[1:0], state.
//  - Reset: state=IDLE, in_ready=1, out_valid=0, product=0, all regs 0, alu_* = 0.
//  - IDLE: in_ready=1; on in_valid: ACC=0, MCD=in_a, MPL=in_b, CNT=0, C=0.
//    Next state is ADD if (in_b[0] | ~SKIP_ADD), else SHIFT.
//  - ADD: alu_s=4'b0000, alu_cin=0, alu_a=ACC, alu_b=MPL[0]?MCD:0.
//    Captures ACC<=alu_result, C<=alu_cout; next state is SHIFT.
//  - SHIFT: alu_s=4'b1011 (rotate right), alu_a=ACC, alu_b=0, alu_cin=0.
//    Updates ACC<={C, alu_result[2:0]}, MPL<={alu_cout, MPL[3:1]}, C<=0.
//    If CNT==3: product<={ACC,MPL} (post-update value) and next state is DONE.
//    Else: CNT++; next state is ADD if (new MPL[0] | ~SKIP_ADD), else SHIFT.
//  - DONE: out_valid=1; product held stable until out_ready; then IDLE next cycle.
//    in_ready stays 0 throughout DONE; no combinational path out_ready->in_ready.
//  - IDLE/DONE: alu_s=0, alu_cin=0, alu_a=0, alu_b=0 (ALU idle-driven).
//  - Latency: accept at cycle T; out_valid first high at T+1+4+N_add.
//    N_add=popcount(in_b) if SKIP_ADD=1, else 4. Range T+5..T+9.
//  - Width: ADD carry-out becomes ACC MSB on the following SHIFT; no overflow possible (15*15=225).
//  - Reset mid-operation: in-flight result discarded; IDLE next cycle; no out_valid pulse.
//  - in_valid while busy: ignored (in_ready=0); source must hold operands.
//  - X on alu_result outside ADD/SHIFT states is ignored (never captured).
// STRUCTURE
//  - alu_ops_pkg (shared): opcode localparams, e.g. ALU_OP_ADD=4'b0000, ALU_OP_SHR=4'b1000,
//    ALU_OP_SHL=4'b1001, ALU_OP_ROL=4'b1010, ALU_OP_ROR=4'b1011, plus the FSM state enum.
//  - No sub-module: single FSM + datapath regs. A top wrapper pairs this block with the ALU.
// TESTING (bench instantiates this block + shift ALU, SKIP_ADD=1 unless stated)
//  1. a=15,b=15 -> product=8'hE1, out_valid at T+9; ADD/SHIFT alternate 4 times.
//  2. a=9,b=0 -> product=0, out_valid at T+5, alu_s never 4'b0000 while busy.
//  3. a=13,b=11 (SKIP_ADD=0) -> product=8'd143 at T+9; same with SKIP_ADD=1 -> T+8.
//  4. out_ready low 5 cycles after out_valid -> product/out_valid stable, in_ready=0;
//     after ready: IDLE next cycle, in_ready=1.
//  5. rst pulsed at T+3 of a=7,b=7 -> next cycle IDLE, in_ready=1, out_valid stays 0.
//  6. Exhaustive 256 pairs, random in_valid/out_ready gaps -> all products match a*b, no drops.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Shared definitions for the shift/add ALU and the controller that
// sequences it.
//  - ALU opcode encodings driven on alu_s.
//  - State enum of the shift-add multiply sequencer.
// No ports; imported with `import alu_ops_pkg::*;`.
package alu_ops_pkg;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SHR = 4'b1000;
  localparam logic [3:0] ALU_OP_SHL = 4'b1001;
  localparam logic [3:0] ALU_OP_ROL = 4'b1010;
  localparam logic [3:0] ALU_OP_ROR = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl
//  Sequencer that drives an external 4-bit shift/add ALU to form the
//  unsigned product of two 4-bit operands using a shift-add loop.
//  One ALU operation (ADD or ROR) is issued per busy cycle. The ALU
//  result and carry are used combinationally in the same cycle.
//
// Ports
//  clk        in   clock, rising edge
//  rst        in   synchronous active-high reset
//  in_valid   in   operand valid
//  in_ready   out  operands accepted (high only in IDLE)
//  in_a       in   multiplicand
//  in_b       in   multiplier
//  out_valid  out  product valid (held until out_ready)
//  out_ready  in   sink accepts product
//  product    out  in_a * in_b
//  alu_s      out  ALU opcode
//  alu_cin    out  ALU carry-in (always 0)
//  alu_a      out  ALU operand A
//  alu_b      out  ALU operand B
//  alu_result in   ALU result
//  alu_cout   in   ALU carry / rotate-out
module shift_add_mul_ctrl
  import alu_ops_pkg::*;
#(
  parameter int DATA_W   = 4,    // only 4 is supported (must match the ALU)
  parameter bit SKIP_ADD = 1'b1  // 1: skip the ADD cycle for a 0 multiplier bit
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   product,
  output logic [3:0]            alu_s,
  output logic                  alu_cin,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_cout
);

  localparam logic [1:0] CNT_LAST = 2'(DATA_W - 1);

  mul_state_e            state_q, state_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]     mpl_q, mpl_d;
  logic [DATA_W-1:0]     mcd_q, mcd_d;
  logic                  c_q, c_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   product_q, product_d;

  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [3:0]            alu_s_q, alu_s_d;
  logic [DATA_W-1:0]     alu_a_q, alu_a_d;
  logic [DATA_W-1:0]     alu_b_q, alu_b_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mpl_d     = mpl_q;
    mcd_d     = mcd_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = '0;
          mcd_d   = in_a;
          mpl_d   = in_b;
          cnt_d   = '0;
          c_d     = 1'b0;
          state_d = (in_b[0] || !SKIP_ADD) ? ST_ADD : ST_SHIFT;
        end
      end
      ST_ADD: begin
        acc_d   = alu_result;
        c_d     = alu_cout;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // The ALU rotates ACC right; its low bits are ACC shifted down and
        // the vacated MSB takes the carry from the preceding ADD. The bit
        // rotated out of ACC becomes the new MSB of the multiplier/low half.
        acc_d = {c_q, alu_result[DATA_W-2:0]};
        mpl_d = {alu_cout, mpl_q[DATA_W-1:1]};
        c_d   = 1'b0;
        if (cnt_q == CNT_LAST) begin
          product_d = {acc_d, mpl_d};
          state_d   = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (mpl_d[0] || !SKIP_ADD) ? ST_ADD : ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so that the ALU sees
    // operands that match the state during the whole cycle.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    alu_s_d     = (state_d == ST_SHIFT) ? ALU_OP_ROR : ALU_OP_ADD;
    alu_a_d     = (state_d == ST_ADD || state_d == ST_SHIFT) ? acc_d : '0;
    alu_b_d     = (state_d == ST_ADD && mpl_d[0]) ? mcd_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      mpl_q       <= '0;
      mcd_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mpl_q       <= mpl_d;
      mcd_q       <= mcd_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign alu_s     = alu_s_q;
  assign alu_cin   = 1'b0;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Testbench for shift_add_mul_ctrl. Two instances are built, index 0 with
// SKIP_ADD=0 and index 1 with SKIP_ADD=1, each paired with a behavioural
// shift/add ALU. Expected products, latencies and opcode sequences come
// from plain arithmetic on the operands.
module tb_shift_add_mul_ctrl;
  import alu_ops_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid_v   [2];
  logic       in_ready_v   [2];
  logic [3:0] in_a_v       [2];
  logic [3:0] in_b_v       [2];
  logic       out_valid_v  [2];
  logic       out_ready_v  [2];
  logic [7:0] product_v    [2];
  logic [3:0] alu_s_v      [2];
  logic       alu_cin_v    [2];
  logic [3:0] alu_a_v      [2];
  logic [3:0] alu_b_v      [2];
  logic [3:0] alu_result_v [2];
  logic       alu_cout_v   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural shift/add ALU: {cout, result}.
  function automatic logic [4:0] alu_model(input logic [3:0] s, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
    case (s)
      ALU_OP_ADD: return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      ALU_OP_SHR: return {a[0], 1'b0, a[3:1]};
      ALU_OP_SHL: return {a[3], a[2:0], 1'b0};
      ALU_OP_ROL: return {a[3], a[2:0], a[3]};
      ALU_OP_ROR: return {a[0], a[0], a[3:1]};
      default:    return 5'bx;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    shift_add_mul_ctrl #(.DATA_W(4), .SKIP_ADD(gi)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_v[gi]),
      .in_ready   (in_ready_v[gi]),
      .in_a       (in_a_v[gi]),
      .in_b       (in_b_v[gi]),
      .out_valid  (out_valid_v[gi]),
      .out_ready  (out_ready_v[gi]),
      .product    (product_v[gi]),
      .alu_s      (alu_s_v[gi]),
      .alu_cin    (alu_cin_v[gi]),
      .alu_a      (alu_a_v[gi]),
      .alu_b      (alu_b_v[gi]),
      .alu_result (alu_result_v[gi]),
      .alu_cout   (alu_cout_v[gi])
    );
    assign {alu_cout_v[gi], alu_result_v[gi]} =
      alu_model(alu_s_v[gi], alu_a_v[gi], alu_b_v[gi], alu_cin_v[gi]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance sk. Called at a negedge; returns at a
  // negedge with the instance back in IDLE. lat is the cycle offset (from
  // the accept cycle) at which out_valid was first seen, 0 on timeout.
  task automatic run_txn(input int sk, input logic [3:0] a, input logic [3:0] b,
                         input int gap, input int hold, output int lat);
    logic [3:0] ops[$];
    logic [3:0] exp_ops[$];
    int exp_lat, n_add, k, bad_ready, bad_ops, bad_hold;
    logic [7:0] exp_prod;

    lat      = 0;
    exp_prod = 8'(a) * 8'(b);
    n_add    = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] || sk == 0) begin
        exp_ops.push_back(ALU_OP_ADD);
        n_add++;
      end
      exp_ops.push_back(ALU_OP_ROR);
    end
    exp_lat = 5 + n_add;

    repeat (gap) @(negedge clk);
    in_a_v[sk]     = a;
    in_b_v[sk]     = b;
    in_valid_v[sk] = 1'b1;
    k = 0;
    while (!in_ready_v[sk] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_v[sk]) begin
      check("accept_timeout", 32'(in_ready_v[sk]), 32'd1);
      in_valid_v[sk] = 1'b0;
      return;
    end
    @(posedge clk);   // accept edge closes cycle T
    @(negedge clk);   // now in cycle T+1
    in_valid_v[sk] = 1'b0;
    in_a_v[sk]     = 4'($urandom);
    in_b_v[sk]     = 4'($urandom);

    k = 1;
    bad_ready = 0;
    while (!out_valid_v[sk] && k < 20) begin
      ops.push_back(alu_s_v[sk]);
      if (in_ready_v[sk] !== 1'b0) bad_ready++;
      @(negedge clk);
      k++;
    end
    if (!out_valid_v[sk]) begin
      check("done_timeout", 32'(out_valid_v[sk]), 32'd1);
      return;
    end
    lat = k;
    check("latency", 32'(lat), 32'(exp_lat));
    check("product", 32'(product_v[sk]), 32'(exp_prod));
    check("busy_in_ready", 32'(bad_ready), 32'd0);

    bad_ops = (ops.size() == exp_ops.size()) ? 0 : 1;
    if (bad_ops == 0)
      foreach (ops[i]) if (ops[i] !== exp_ops[i]) bad_ops++;
    check("op_sequence", 32'(bad_ops), 32'd0);
    check("done_alu_idle", {19'd0, alu_s_v[sk], alu_a_v[sk], alu_b_v[sk], alu_cin_v[sk]}, 32'd0);

    bad_hold = 0;
    repeat (hold) begin
      @(negedge clk);
      if (out_valid_v[sk] !== 1'b1 || product_v[sk] !== exp_prod || in_ready_v[sk] !== 1'b0)
        bad_hold++;
    end
    check("hold_stable", 32'(bad_hold), 32'd0);
    out_ready_v[sk] = 1'b1;
    @(negedge clk);
    out_ready_v[sk] = 1'b0;
    check("release_idle", {30'd0, out_valid_v[sk], in_ready_v[sk]}, 32'b01);
    $display("txn skip=%0d a=%0d b=%0d product=%0d lat=%0d", sk, a, b, product_v[sk], lat);
  endtask

  initial begin
    int lat;
    int bad;

    for (int i = 0; i < 2; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
      in_a_v[i]      = '0;
      in_b_v[i]      = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 32'(in_ready_v[i]), 32'd1);
      check("rst_out_valid", 32'(out_valid_v[i]), 32'd0);
      check("rst_product", 32'(product_v[i]), 32'd0);
      check("rst_alu", {19'd0, alu_s_v[i], alu_a_v[i], alu_b_v[i], alu_cin_v[i]}, 32'd0);
    end

    // Directed cases with explicit latencies
    run_txn(1, 4'd15, 4'd15, 0, 0, lat);
    check("t1_lat", 32'(lat), 32'd9);
    run_txn(1, 4'd9, 4'd0, 0, 0, lat);
    check("t2_lat", 32'(lat), 32'd5);
    run_txn(0, 4'd13, 4'd11, 0, 0, lat);
    check("t3_lat_noskip", 32'(lat), 32'd9);
    run_txn(1, 4'd13, 4'd11, 0, 0, lat);
    check("t3_lat_skip", 32'(lat), 32'd8);
    run_txn(1, 4'd6, 4'd5, 1, 5, lat);
    check("t4_lat", 32'(lat), 32'd7);

    // Reset in the middle of a=7,b=7
    in_a_v[1] = 4'd7;
    in_b_v[1] = 4'd7;
    in_valid_v[1] = 1'b1;
    @(posedge clk);                // accept (cycle T)
    @(negedge clk);                // cycle T+1
    in_valid_v[1] = 1'b0;
    @(negedge clk);                // cycle T+2
    @(negedge clk);                // cycle T+3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready_v[1]), 32'd1);
    check("midrst_out_valid", 32'(out_valid_v[1]), 32'd0);
    check("midrst_alu_s", 32'(alu_s_v[1]), 32'd0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) bad++;
    end
    check("midrst_quiet", 32'(bad), 32'd0);

    // Exhaustive on SKIP_ADD=1 with random handshake gaps
    for (int p = 0; p < 256; p++)
      run_txn(1, 4'(p >> 4), 4'(p), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), lat);

    // Random sample on SKIP_ADD=0
    for (int p = 0; p < 32; p++)
      run_txn(0, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
